iir_filter_n: RTL and testbench

- Parametrised N-th order direct-form-I IIR filter with fixed-point coefficients.
- Connects between an input FIFO and an output FIFO in the FM demod chain, for example as de-emphasis or audio shaping.
- Uses one time-shared multiplier driven by a MAC state machine.
- Reads and writes only through proper empty/full handshakes and stalls on back-pressure.

---
 rtl/iir_pkg.sv | 42 ++++
 rtl/iir_mac.sv | 39 +++
 rtl/iir_filter_n.sv | 195 +++++++++++++++++++
 tb/tb_iir_filter_n.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared definitions for the iir_filter_n time-shared IIR filter:
// FSM state encoding, default coefficient sets, accumulator sizing and
// the truncate-toward-zero dequantiser used on every product.
package iir_pkg;

  // Largest filter order the coefficient parameter arrays can describe.
  localparam int MAX_ORDER = 8;

  // Width used internally by the dequantiser; products are sign-extended to it.
  localparam int DEQ_WIDTH = 128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WRITE
  } state_t;

  // Entries beyond ORDER are ignored; a[0] is ignored as well.
  localparam longint DEFAULT_B_COEFFS [0:MAX_ORDER] = '{178, 178, 0, 0, 0, 0, 0, 0, 0};
  localparam longint DEFAULT_A_COEFFS [0:MAX_ORDER] = '{0, -666, 0, 0, 0, 0, 0, 0, 0};

  // Accumulator width: sample width plus growth for 2*ORDER+1 terms plus a guard bit.
  function automatic int acc_width(input int data_width, input int order);
    return data_width + $clog2(2 * order + 1) + 1;
  endfunction

  // Signed division by 2^frac_bits rounding toward zero. Negative values are
  // shifted as magnitudes so that e.g. -118548 / 1024 gives -115, not -116.
  function automatic logic signed [DEQ_WIDTH-1:0] dequantize(
    input logic signed [DEQ_WIDTH-1:0] value,
    input int                          frac_bits
  );
    logic signed [DEQ_WIDTH-1:0] magnitude;
    magnitude = value;
    if (value < 0) begin
      magnitude = -value;
      return -(magnitude >> frac_bits);
    end
    return magnitude >> frac_bits;
  endfunction

endpackage

// File: rtl/iir_mac.sv
// Single multiply / dequantise / accumulate datapath shared by all taps of
// iir_filter_n. One product is folded into the accumulator per enabled cycle.
module iir_mac
  import iir_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 32,
  parameter int FRAC_BITS   = 10,
  parameter int ACC_WIDTH   = 35
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enable,
  input  logic signed [COEFF_WIDTH-1:0] coeff,
  input  logic signed [DATA_WIDTH-1:0]  sample,
  output logic signed [ACC_WIDTH-1:0]   acc
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic signed [PROD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  term;

  assign product = PROD_WIDTH'(coeff) * PROD_WIDTH'(sample);
  assign term    = ACC_WIDTH'(dequantize(DEQ_WIDTH'(product), FRAC_BITS));

  // Accumulator: clear takes priority so a new sample always starts from zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/iir_filter_n.sv
// N-th order direct-form-I IIR filter between a first-word-fall-through
// input FIFO and an output FIFO. One sample is read, 2*ORDER+1 products are
// accumulated on a shared multiplier, then the result is written out,
// stalling in S_WRITE while the output FIFO is full.
// Optional build macro IIR_SATURATE_EN: clamp the result to the DATA_WIDTH
// signed range instead of wrapping; the clamped value feeds the y history.
module iir_filter_n
  import iir_pkg::*;
#(
  parameter int     DATA_WIDTH  = 32,
  parameter int     ORDER       = 2,
  parameter int     COEFF_WIDTH = 32,
  parameter int     FRAC_BITS   = 10,
  parameter longint B_COEFFS [0:MAX_ORDER] = DEFAULT_B_COEFFS,
  parameter longint A_COEFFS [0:MAX_ORDER] = DEFAULT_A_COEFFS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, ORDER);
  localparam int NUM_TAPS  = 2 * ORDER + 1;
  localparam int TAP_WIDTH = $clog2(NUM_TAPS);
  localparam logic [TAP_WIDTH-1:0] LAST_TAP = TAP_WIDTH'(NUM_TAPS - 1);

  state_t                        state;
  state_t                        state_next;
  logic [TAP_WIDTH-1:0]          tap;
  logic [TAP_WIDTH-1:0]          tap_next;
  logic                          rd_en_next;
  logic                          wr_en_next;
  logic                          x_shift;
  logic                          y_shift;
  logic                          dout_load;
  logic                          mac_clear;
  logic                          mac_enable;
  logic signed [DATA_WIDTH-1:0]  x_hist [0:ORDER];
  logic signed [DATA_WIDTH-1:0]  y_hist [1:ORDER];
  logic signed [COEFF_WIDTH-1:0] coeff_sel;
  logic signed [DATA_WIDTH-1:0]  sample_sel;
  logic signed [ACC_WIDTH-1:0]   acc;
  logic signed [DATA_WIDTH-1:0]  result;

  // State, tap counter and the registered FIFO strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tap       <= '0;
      in_rd_en  <= 1'b0;
      out_wr_en <= 1'b0;
    end else begin
      state     <= state_next;
      tap       <= tap_next;
      in_rd_en  <= rd_en_next;
      out_wr_en <= wr_en_next;
    end
  end

  // Next-state and control decode; out_full is only looked at in S_WRITE.
  always_comb begin
    state_next = state;
    tap_next   = tap;
    rd_en_next = 1'b0;
    wr_en_next = 1'b0;
    x_shift    = 1'b0;
    y_shift    = 1'b0;
    dout_load  = 1'b0;
    mac_clear  = 1'b0;
    mac_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (!in_empty) begin
          rd_en_next = 1'b1;
          x_shift    = 1'b1;
          mac_clear  = 1'b1;
          tap_next   = '0;
          state_next = S_MAC;
        end
      end
      S_MAC: begin
        mac_enable = 1'b1;
        if (tap == LAST_TAP) begin
          tap_next   = '0;
          state_next = S_WRITE;
        end else begin
          tap_next = tap + TAP_WIDTH'(1);
        end
      end
      S_WRITE: begin
        dout_load = 1'b1;
        if (!out_full) begin
          wr_en_next = 1'b1;
          y_shift    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand select: taps 0..ORDER walk b/x, taps ORDER+1..2*ORDER walk a/y.
  always_comb begin
    coeff_sel  = '0;
    sample_sel = '0;
    for (int k = 0; k <= ORDER; k++) begin
      if (tap == TAP_WIDTH'(k)) begin
        coeff_sel  = COEFF_WIDTH'(B_COEFFS[k]);
        sample_sel = x_hist[k];
      end
    end
    for (int k = 1; k <= ORDER; k++) begin
      if (tap == TAP_WIDTH'(ORDER + k)) begin
        coeff_sel  = COEFF_WIDTH'(A_COEFFS[k]);
        sample_sel = y_hist[k];
      end
    end
  end

  // Input history: the newly read sample enters x[0] as older ones age.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= ORDER; k++) begin
        x_hist[k] <= '0;
      end
    end else if (x_shift) begin
      x_hist[0] <= din;
      for (int k = 1; k <= ORDER; k++) begin
        x_hist[k] <= x_hist[k-1];
      end
    end
  end

  // Output register and feedback history; y only advances on an actual write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout <= '0;
      for (int k = 1; k <= ORDER; k++) begin
        y_hist[k] <= '0;
      end
    end else begin
      if (dout_load) begin
        dout <= result;
      end
      if (y_shift) begin
        y_hist[1] <= result;
        for (int k = 2; k <= ORDER; k++) begin
          y_hist[k] <= y_hist[k-1];
        end
      end
    end
  end

`ifdef IIR_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  // Clamp the accumulator into the signed DATA_WIDTH range.
  always_comb begin
    result = DATA_WIDTH'(acc);
    if (acc > SAT_MAX) begin
      result = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (acc < SAT_MIN) begin
      result = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
  end
`else
  assign result = DATA_WIDTH'(acc);
`endif

  iir_mac #(
    .DATA_WIDTH  (DATA_WIDTH),
    .COEFF_WIDTH (COEFF_WIDTH),
    .FRAC_BITS   (FRAC_BITS),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_mac (
    .clock  (clock),
    .reset  (reset),
    .clear  (mac_clear),
    .enable (mac_enable),
    .coeff  (coeff_sel),
    .sample (sample_sel),
    .acc    (acc)
  );

endmodule

// File: tb/tb_iir_filter_n.sv
// Self-checking bench for iir_filter_n. A first-order filter (b={178,178},
// a={0,-666}) and a first-order overflow filter (b={1024,1024}, a=0) share
// the same input stimulus; expected outputs are queued when a sample is
// offered and popped when the corresponding DUT writes.
module tb_iir_filter_n;

  localparam int DW     = 32;
  localparam int ORDER  = 1;
  // Cycles counted inclusively from the in_rd_en cycle to the out_wr_en cycle.
  localparam int LAT    = 2 * ORDER + 3;
  // Cycles between consecutive out_wr_en pulses when input is always available.
  localparam int PERIOD = 2 * ORDER + 3;
  localparam int BOUND  = 100;

`ifdef IIR_SATURATE_EN
  localparam logic [31:0] OVF_SECOND = 32'h7FFFFFFF;
`else
  localparam logic [31:0] OVF_SECOND = 32'hFFFFFFFE;
`endif

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic [DW-1:0] din      = '0;
  logic          in_empty = 1'b1;
  logic          out_full = 1'b0;
  logic          in_rd_en;
  logic          out_wr_en;
  logic [DW-1:0] dout;
  logic          ovf_rd_en;
  logic          ovf_wr_en;
  logic [DW-1:0] ovf_dout;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] ovf_q [$];

  always #5 clock = ~clock;

  iir_filter_n #(
    .DATA_WIDTH  (DW),
    .ORDER       (ORDER),
    .COEFF_WIDTH (32),
    .FRAC_BITS   (10),
    .B_COEFFS    ('{178, 178, 0, 0, 0, 0, 0, 0, 0}),
    .A_COEFFS    ('{0, -666, 0, 0, 0, 0, 0, 0, 0})
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .dout      (dout),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  iir_filter_n #(
    .DATA_WIDTH  (DW),
    .ORDER       (ORDER),
    .COEFF_WIDTH (32),
    .FRAC_BITS   (10),
    .B_COEFFS    ('{1024, 1024, 0, 0, 0, 0, 0, 0, 0}),
    .A_COEFFS    ('{0, 0, 0, 0, 0, 0, 0, 0, 0})
  ) dut_ovf (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .in_empty  (in_empty),
    .in_rd_en  (ovf_rd_en),
    .dout      (ovf_dout),
    .out_full  (out_full),
    .out_wr_en (ovf_wr_en)
  );

  // The read and write strobes must never coincide in either instance.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert (!(in_rd_en && out_wr_en) && !(ovf_rd_en && ovf_wr_en)) else begin
        failures++;
        $error("[TB] FAIL rd_wr_same_cycle observed rd=%0b wr=%0b ovf_rd=%0b ovf_wr=%0b expected no overlap",
               in_rd_en, out_wr_en, ovf_rd_en, ovf_wr_en);
      end
    end
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Wait for the DUT to pop the offered sample, then withdraw it.
  task automatic waitRead();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!in_rd_en && n < BOUND);
    checkValue("read_seen", {31'd0, in_rd_en}, 32'd1);
    in_empty = 1'b1;
  endtask

  task automatic driveSample(input logic [31:0] value);
    @(negedge clock);
    din      = value;
    in_empty = 1'b0;
    waitRead();
  endtask

  task automatic applyStimulus(input logic [31:0] value, input logic [31:0] expected, input bit use_ovf);
    if (use_ovf) ovf_q.push_back(expected);
    else         exp_q.push_back(expected);
    driveSample(value);
  endtask

  // Wait for a write, compare against the scoreboard and optionally check
  // how many cycles it took (counter starts at start_n).
  task automatic checkOutput(input bit use_ovf, input int exp_cycles, input int start_n);
    int   n = start_n;
    logic wr;
    do begin
      @(negedge clock);
      n++;
      wr = use_ovf ? ovf_wr_en : out_wr_en;
    end while (!wr && n < start_n + BOUND);
    if (use_ovf) begin
      checkValue("ovf_wr_seen", {31'd0, ovf_wr_en}, 32'd1);
      checks++;
      assert (ovf_q.size() != 0) else begin
        failures++;
        $error("[TB] FAIL ovf_scoreboard observed=empty expected=entry");
      end
      if (ovf_q.size() != 0) checkValue("ovf_dout", ovf_dout, ovf_q.pop_front());
    end else begin
      checkValue("wr_seen", {31'd0, out_wr_en}, 32'd1);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("[TB] FAIL scoreboard observed=empty expected=entry");
      end
      if (exp_q.size() != 0) checkValue("dout", dout, exp_q.pop_front());
    end
    if (exp_cycles != 0) checkValue("cycles", 32'(n), 32'(exp_cycles));
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
    in_empty = 1'b1;
    out_full = 1'b0;
    exp_q.delete();
    ovf_q.delete();
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    repeat (3) @(negedge clock);
    checkValue("reset_dout", dout, 32'd0);
    checkValue("reset_rd", {31'd0, in_rd_en}, 32'd0);
    checkValue("reset_wr", {31'd0, out_wr_en}, 32'd0);
    checkValue("reset_ovf_dout", ovf_dout, 32'd0);
    reset = 1'b0;

    // Gapped impulse; out_full toggles during MAC on the second sample
    applyStimulus(32'd1024, 32'd178, 1'b0);
    checkOutput(1'b0, LAT, 1);
    applyStimulus(32'd0, 32'd63, 1'b0);
    out_full = 1'b1;
    @(negedge clock);
    @(negedge clock);
    out_full = 1'b0;
    checkOutput(1'b0, LAT, 3);
    applyStimulus(32'd0, -32'sd40, 1'b0);
    checkOutput(1'b0, LAT, 1);

    // Step with the input FIFO never empty
    pulseReset();
    din      = 32'd1024;
    in_empty = 1'b0;
    exp_q.push_back(32'd178);
    exp_q.push_back(32'd241);
    exp_q.push_back(32'd200);
    checkOutput(1'b0, 0, 0);
    checkOutput(1'b0, PERIOD, 0);
    checkOutput(1'b0, PERIOD, 0);
    in_empty = 1'b1;

    // Reset in the middle of a MAC run after three samples
    driveSample(32'd1024);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkValue("midmac_reset_dout", dout, 32'd0);
    checkValue("midmac_reset_rd", {31'd0, in_rd_en}, 32'd0);
    checkValue("midmac_reset_wr", {31'd0, out_wr_en}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    ovf_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checkValue("no_write_after_reset", {31'd0, out_wr_en}, 32'd0);
    end
    applyStimulus(32'd0, 32'd0, 1'b0);
    checkOutput(1'b0, LAT, 1);
    applyStimulus(32'd0, 32'd0, 1'b0);
    checkOutput(1'b0, LAT, 1);
    applyStimulus(32'd1024, 32'd178, 1'b0);
    checkOutput(1'b0, LAT, 1);
    applyStimulus(32'd0, 32'd63, 1'b0);
    checkOutput(1'b0, LAT, 1);
    applyStimulus(32'd0, -32'sd40, 1'b0);
    checkOutput(1'b0, LAT, 1);

    // Back-pressure: 20 stalled cycles in S_WRITE with input waiting
    pulseReset();
    out_full = 1'b1;
    applyStimulus(32'd1024, 32'd178, 1'b0);
    repeat (4) @(negedge clock);
    din      = 32'd0;
    in_empty = 1'b0;
    exp_q.push_back(32'd63);
    for (int i = 0; i < 20; i++) begin
      checkValue("stall_dout", dout, 32'd178);
      checkValue("stall_wr", {31'd0, out_wr_en}, 32'd0);
      checkValue("stall_rd", {31'd0, in_rd_en}, 32'd0);
      @(negedge clock);
    end
    out_full = 1'b0;
    checkOutput(1'b0, 1, 0);
    waitRead();
    checkValue("single_write", {31'd0, out_wr_en}, 32'd0);
    checkOutput(1'b0, LAT, 1);

    // Overflow on the b={1024,1024} instance
    pulseReset();
    applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
    checkOutput(1'b1, LAT, 1);
    applyStimulus(32'h7FFFFFFF, OVF_SECOND, 1'b1);
    checkOutput(1'b1, LAT, 1);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
